// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
// The master is the EX stage; the slave is mdu_iter.
interface mdu_iter_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: WIDTH shift steps on
// unsigned magnitudes, then one fix-up cycle applying signs and writing HI/LO.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       rst,
    mdu_iter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               div_q;      // 1: divide, 0: multiply
    logic               neg_q;      // negate product / quotient
    logic               negr_q;     // negate remainder (dividend sign)
    logic               divz_q;     // divide by zero
    logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   araw_q;     // raw dividend, HI result on divide by zero
    logic [2*WIDTH-1:0] acc_q;      // {HI part, LO part} working register

    // Operand decode at issue
    logic             is_signed, is_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        a_neg     = is_signed && bus.a[WIDTH-1];
        b_neg     = is_signed && bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
    end

    // One shift-add step: add multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // One restoring-division step: remainder in the upper half, dividend
    // bits shift out of the lower half as quotient bits shift in.
    logic [WIDTH:0]     rem_sh, trial;
    logic [2*WIDTH-1:0] div_acc;

    always_comb begin
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        trial   = rem_sh - {1'b0, opb_q};
        div_acc = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Sign fix-up of the finished magnitudes
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (!div_q) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (divz_q) begin
            fix_hi = araw_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
            opb_q   <= '0;
            araw_q  <= '0;
            acc_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (bus.op <= OP_DIVU) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            div_q   <= is_div;
                            neg_q   <= a_neg ^ b_neg;
                            negr_q  <= a_neg;
                            divz_q  <= is_div && (bus.b == '0);
                            araw_q  <= bus.a;
                            if (is_div) begin
                                opb_q <= b_mag;
                                acc_q <= {{WIDTH{1'b0}}, a_mag};
                            end else begin
                                opb_q <= a_mag;
                                acc_q <= {{WIDTH{1'b0}}, b_mag};
                            end
                        end else if (bus.op == OP_MTHI) begin
                            hi_q   <= bus.a;
                            done_q <= 1'b1;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q   <= bus.a;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= div_q ? div_acc : mul_acc;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= FIX;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!bus.flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It sits beside the EX-stage ALU: EX issues an operation with a one-cycle `start`, and the unit runs for WIDTH+1 cycles while raising `busy` so the pipeline controller can stall dependent MFHI/MFLO or later MDU instructions. It is the first multi-cycle execution resource in the core, with operand width set by parameter.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits; must be even and ≥ 4
- `clock` in 1: single clock; all state updates on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: issue request; sampled only in IDLE
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops (ignored, no `done`)
- `a` in WIDTH: rs operand (dividend / multiplicand / MTHI–MTLO source)
- `b` in WIDTH: rt operand (divisor / multiplier)
- `flush` in 1: abort the in-flight operation (pipeline flush of the issuing instruction)
- `busy` out 1: operation in progress; HI/LO not valid for reading
- `done` out 1: one-cycle pulse; HI/LO were updated on the preceding edge
- `hi` out WIDTH: HI register
- `lo` out WIDTH: LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `start` + op 0–3: latch operand magnitudes, sign flags, op, and zero the iteration counter. Go to RUN. `busy` becomes 1.
- IDLE + `start` + op 4/5: write `a` to HI (4) or LO (5) on that edge. Stay IDLE. `done` pulses. `busy` stays 0.
- RUN, multiply: one shift-add step per cycle on unsigned magnitudes into a 2·WIDTH accumulator.
- RUN, divide: one restoring-division step per cycle (shift remainder, trial subtract, set quotient bit) on unsigned magnitudes.
- RUN lasts exactly WIDTH cycles (counter 0..WIDTH-1), then the unit goes to FIX.
- FIX applies signs and writes HI/LO, returns to IDLE, drops `busy`, and pulses `done`.
  - Signed multiply (op 0): the 2·WIDTH product is negated if the operand signs differ. HI = upper half, LO = lower half.
  - Signed divide (op 2): the quotient is negated if the operand signs differ. The remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - Unsigned ops (1, 3): no sign correction.
- Magnitude of the most-negative value is 2^(WIDTH-1), which fits in WIDTH unsigned bits; no extra bit is needed.
- Signed DIV of the most-negative value by -1 gives LO = 2^(WIDTH-1) bit pattern and HI = 0 (wrap, no trap).
- Divide by zero (op 2 or 3, `b` = 0): HI = `a` unmodified, LO = all ones. The same WIDTH+1 latency applies, so timing is uniform.
- `start` while `busy`: ignored. No queueing, and no effect on the operation in flight.
- `flush` in RUN or FIX: return to IDLE on the next edge. HI/LO are unchanged, no `done` is issued, and `busy` falls.
- `flush` and `start` asserted together in IDLE: `flush` wins and nothing is issued, including MTHI/MTLO.
- HI/LO change only on a FIX edge or an MTHI/MTLO edge.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, counter 0. Reset asserted mid-operation aborts immediately. No `done` follows deassertion.
- Start accepted at edge E0. `busy` = 1 from after E0 through E_WIDTH. FIX occupies the cycle after E_WIDTH.
- At edge E_(WIDTH+1), HI/LO are written and `busy` goes 0. `done` = 1 for exactly the cycle after E_(WIDTH+1).
- Total latency for ops 0–3 is WIDTH+1 cycles (33 for WIDTH = 32).
- A new `start` is accepted in the same cycle `done` is high; the unit is back-to-back capable.
- MTHI/MTLO: HI/LO are updated at E0, and `done` is high for the cycle after E0.
- `busy`, `done`, `hi`, and `lo` are all registered outputs. They have no combinational path from the inputs.

## Test plan
- Reset, then MULT `a`=0xFFFFFFFD (-3), `b`=5 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1. `done` is a single pulse and `busy` was high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Back-to-back MULTU 6×7, issued in the `done` cycle → HI=0, LO=42.
- DIV -7 (0xFFFFFFF9) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100 / 0 → HI=100, LO=0xFFFFFFFF after 33 cycles. DIVU 100 / 7 → LO=14, HI=2.
- MTHI 0x12345678 then MTLO 0xCAFEBABE, each a single cycle → HI and LO update one edge after issue with a `done` pulse each. A `start` MULT issued at cycle 5 of a running DIV is ignored, and the DIV result is unaffected.
- With HI/LO preloaded to 0xAAAA5555/0x5555AAAA, issue DIV, assert `flush` at RUN cycle 10 → no `done`, `busy` 0 next cycle, HI/LO unchanged. Repeat with `rst` pulsed at RUN cycle 10 → all outputs 0 at once.
